// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and the wrapping
// pointer increment shared by the fifo_fwft slice.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Next pointer for a ring of 'depth' entries,
  // wrapping depth-1 -> 0 (depth need not be 2^n).
  function automatic int ptr_inc(
    input int ptr,
    input int depth
  );
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: simple dual-port word array.
// Ports: clk, rst_n (async, active low),
//   we_i/waddr_i/wdata_i  synchronous write port,
//   re_i/raddr_i          registered read request,
//   rdata_o               read register, reset to 0,
//                         holds value when re_i is low.
module fifo_ram_2p #(
  parameter int W  = 8,
  parameter int D  = 16,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_fwft.sv
// fifo_fwft: single-clock FIFO, any depth >= 2,
// standard or first-word-fall-through read mode.
// Ports: clk, reset (async, active low);
//   write: fifoWrEn, fifoWrData, fifoFull,
//          fifoAlmostFull;
//   read:  fifoRdEn, fifoRdData, fifoRdValid,
//          fifoEmpty, fifoAlmostEmpty;
//   fifoDataCount (words held, incl. FWFT head);
//   clrErr, fifoOverflow, fifoUnderflow (sticky).
module fifo_fwft
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifoWrEn,
  input  logic [FIFO_WIDTH-1:0] fifoWrData,
  output logic                  fifoFull,
  output logic                  fifoAlmostFull,
  input  logic                  fifoRdEn,
  output logic [FIFO_WIDTH-1:0] fifoRdData,
  output logic                  fifoRdValid,
  output logic                  fifoEmpty,
  output logic                  fifoAlmostEmpty,
  output logic [CW-1:0]         fifoDataCount,
  input  logic                  clrErr,
  output logic                  fifoOverflow,
  output logic                  fifoUnderflow
);

  localparam bit IS_FWFT =
    (FWFT == FIFO_MODE_FWFT);
  localparam logic [CW-1:0] DEPTH_C =
    CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C =
    CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C =
    CW'(AEMPTY_THRESH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          full, empty;
  logic          wr_acc, rd_acc, ram_re;
  logic [CW-1:0] ram_cnt;

  assign full   = (cnt_q == DEPTH_C);
  assign empty  = IS_FWFT ? ~vld_q
                          : (cnt_q == '0);
  assign wr_acc = fifoWrEn & ~full;
  assign rd_acc = fifoRdEn & ~empty;

  // In FWFT the head word lives in the output
  // register, so the RAM holds one fewer.
  assign ram_cnt = cnt_q
                 - CW'(IS_FWFT && vld_q);

  // FWFT prefetch: refill the head register
  // whenever it is free or being popped.
  assign ram_re = IS_FWFT
    ? ((ram_cnt != '0) & (~vld_q | rd_acc))
    : rd_acc;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = IS_FWFT ? (vld_q & ~rd_acc)
                       : 1'b0;
    if (wr_acc) begin
      wr_ptr_d = AW'(ptr_inc(int'(wr_ptr_q),
                             FIFO_DEPTH));
    end
    if (ram_re) begin
      rd_ptr_d = AW'(ptr_inc(int'(rd_ptr_q),
                             FIFO_DEPTH));
      vld_d    = 1'b1;
    end
    unique case (1'b1)
      wr_acc & ~rd_acc: cnt_d = cnt_q + CW'(1);
      ~wr_acc & rd_acc: cnt_d = cnt_q - CW'(1);
      default:          cnt_d = cnt_q;
    endcase
    // a set in the same cycle beats clrErr
    ovf_d = (fifoWrEn & full)
          | (ovf_q & ~clrErr);
    udf_d = (fifoRdEn & empty)
          | (udf_q & ~clrErr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram_2p #(
    .W (FIFO_WIDTH),
    .D (FIFO_DEPTH),
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (reset),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(fifoWrData),
    .re_i   (ram_re),
    .raddr_i(rd_ptr_q),
    .rdata_o(fifoRdData)
  );

  assign fifoFull        = full;
  assign fifoEmpty       = empty;
  assign fifoAlmostFull  = (cnt_q >= AF_C);
  assign fifoAlmostEmpty = (cnt_q <= AE_C);
  assign fifoDataCount   = cnt_q;
  assign fifoRdValid     = vld_q;
  assign fifoOverflow    = ovf_q;
  assign fifoUnderflow   = udf_q;

endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: three fifo_fwft instances
// (16/std, 16/FWFT, 5/std thresholds 4,1).
module tb_fifo_fwft;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [7:0] wd = '0;

  logic       full_o   [3];
  logic       afull_o  [3];
  logic       vld_o    [3];
  logic       empty_o  [3];
  logic       aempty_o [3];
  logic       ovf_o    [3];
  logic       udf_o    [3];
  logic [7:0] data_o   [3];
  logic [4:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;

  int nchk = 0;
  int nerr = 0;
  int sel, mdep, maf, mae, mcnt;
  bit movf, mudf;
  logic [7:0] sbq [$];

  typedef struct {
    bit w;
    bit r;
    int cnt;
    bit ae;
    bit af;
    bit full;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  fifo_fwft #(
    .FIFO_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)
  ) u_a (
    .clk(clk), .reset(rst_n),
    .fifoWrEn(wr), .fifoWrData(wd),
    .fifoFull(full_o[0]),
    .fifoAlmostFull(afull_o[0]),
    .fifoRdEn(rd), .fifoRdData(data_o[0]),
    .fifoRdValid(vld_o[0]),
    .fifoEmpty(empty_o[0]),
    .fifoAlmostEmpty(aempty_o[0]),
    .fifoDataCount(cnt_a), .clrErr(clr),
    .fifoOverflow(ovf_o[0]),
    .fifoUnderflow(udf_o[0])
  );

  fifo_fwft #(
    .FIFO_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)
  ) u_b (
    .clk(clk), .reset(rst_n),
    .fifoWrEn(wr), .fifoWrData(wd),
    .fifoFull(full_o[1]),
    .fifoAlmostFull(afull_o[1]),
    .fifoRdEn(rd), .fifoRdData(data_o[1]),
    .fifoRdValid(vld_o[1]),
    .fifoEmpty(empty_o[1]),
    .fifoAlmostEmpty(aempty_o[1]),
    .fifoDataCount(cnt_b), .clrErr(clr),
    .fifoOverflow(ovf_o[1]),
    .fifoUnderflow(udf_o[1])
  );

  fifo_fwft #(
    .FIFO_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0),
    .AFULL_THRESH(4), .AEMPTY_THRESH(1)
  ) u_c (
    .clk(clk), .reset(rst_n),
    .fifoWrEn(wr), .fifoWrData(wd),
    .fifoFull(full_o[2]),
    .fifoAlmostFull(afull_o[2]),
    .fifoRdEn(rd), .fifoRdData(data_o[2]),
    .fifoRdValid(vld_o[2]),
    .fifoEmpty(empty_o[2]),
    .fifoAlmostEmpty(aempty_o[2]),
    .fifoDataCount(cnt_c), .clrErr(clr),
    .fifoOverflow(ovf_o[2]),
    .fifoUnderflow(udf_o[2])
  );

  function automatic logic [4:0] ocnt();
    case (sel)
      0:       return cnt_a;
      1:       return cnt_b;
      default: return {1'b0, cnt_c};
    endcase
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string t);
    chk({t, "cnt"},    ocnt(),         0);
    chk({t, "empty"},  empty_o[sel],   1);
    chk({t, "full"},   full_o[sel],    0);
    chk({t, "aempty"}, aempty_o[sel],  1);
    chk({t, "afull"},  afull_o[sel],   0);
    chk({t, "vld"},    vld_o[sel],     0);
    chk({t, "data"},   data_o[sel],    0);
    chk({t, "ovf"},    ovf_o[sel],     0);
    chk({t, "udf"},    udf_o[sel],     0);
  endtask

  task automatic mdl_clear();
    mcnt = 0;
    movf = 1'b0;
    mudf = 1'b0;
    sbq.delete();
  endtask

  task automatic do_reset(
    input int s, input int dep,
    input int af, input int ae
  );
    sel = s; mdep = dep; maf = af; mae = ae;
    wr = 0; rd = 0; clr = 0; wd = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_rst("rst_");
    rst_n = 1'b1;
    mdl_clear();
  endtask

  // One cycle on a standard-mode instance,
  // entered and left on a falling edge.
  task automatic step(
    input bit w, input logic [7:0] d,
    input bit r, input bit c
  );
    bit wacc, racc;
    logic [7:0] e;
    wr = w; wd = d; rd = r; clr = c;
    wacc = w && (mcnt < mdep);
    racc = r && (mcnt > 0);
    movf = (w && mcnt == mdep) ? 1'b1
         : (c ? 1'b0 : movf);
    mudf = (r && mcnt == 0) ? 1'b1
         : (c ? 1'b0 : mudf);
    @(negedge clk);
    mcnt = mcnt + int'(wacc) - int'(racc);
    if (wacc) sbq.push_back(d);
    chk("rdvalid", vld_o[sel], racc);
    if (racc) begin
      e = sbq.pop_front();
      chk("rddata", data_o[sel], e);
    end
    chk("count",  ocnt(),        mcnt);
    chk("full",   full_o[sel],   mcnt == mdep);
    chk("empty",  empty_o[sel],  mcnt == 0);
    chk("afull",  afull_o[sel],  mcnt >= maf);
    chk("aempty", aempty_o[sel], mcnt <= mae);
    chk("ovf",    ovf_o[sel],    movf);
    chk("udf",    udf_o[sel],    mudf);
  endtask

  initial begin
    logic [7:0] e;
    tbl[0]  = '{1, 0, 1, 1, 0, 0};
    tbl[1]  = '{1, 0, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 3, 0, 0, 0};
    tbl[3]  = '{1, 0, 4, 0, 1, 0};
    tbl[4]  = '{1, 0, 5, 0, 1, 1};
    tbl[5]  = '{1, 0, 5, 0, 1, 1};
    tbl[6]  = '{0, 1, 4, 0, 1, 0};
    tbl[7]  = '{0, 1, 3, 0, 0, 0};
    tbl[8]  = '{1, 1, 3, 0, 0, 0};
    tbl[9]  = '{0, 1, 2, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 1, 0, 0};
    #1;

    // depth 16, standard mode
    do_reset(0, 16, 14, 2);
    for (int i = 0; i < 16; i++)
      step(1, 8'(i), 0, 0);
    chk("full16", full_o[0], 1);
    chk("cnt16", cnt_a, 16);
    step(1, 8'h55, 0, 0);
    chk("ovf17", ovf_o[0], 1);
    chk("cnt17", cnt_a, 16);
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 1, 0);
      chk("order", data_o[0], i);
    end
    step(0, '0, 0, 0);
    chk("vld_one", vld_o[0], 0);
    chk("hold", data_o[0], 8'h0F);
    step(0, '0, 1, 0);
    chk("udf_set", udf_o[0], 1);
    step(0, '0, 1, 1);
    chk("set_wins", udf_o[0], 1);
    step(0, '0, 0, 1);
    chk("udf_clr", udf_o[0], 0);
    for (int i = 0; i < 4; i++)
      step(1, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 10; i++)
      step(1, 8'(8'h80 + i), 1, 0);
    chk("thru_cnt", cnt_a, 4);
    while (mcnt < 16)
      step(1, 8'($urandom), 0, 0);
    step(1, 8'hEE, 1, 0);
    chk("full_wr_rd", cnt_a, 15);
    step(0, '0, 0, 1);
    while (mcnt > 0)
      step(0, '0, 1, 0);

    // asynchronous reset mid-burst at count 7
    for (int i = 0; i < 7; i++)
      step(1, 8'(8'h60 + i), 0, 0);
    chk("pre_rst_cnt", cnt_a, 7);
    #2;
    wr = 0; rst_n = 1'b0;
    #1;
    chk_rst("mid_");
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    step(1, 8'h3C, 0, 0);
    step(0, '0, 1, 0);
    chk("post_rst", data_o[0], 8'h3C);

    // depth 16, FWFT
    do_reset(1, 16, 14, 2);
    wr = 1; wd = 8'hA5;
    sbq.push_back(8'hA5);
    @(negedge clk);
    wr = 0;
    chk("fw_n_vld", vld_o[1], 0);
    chk("fw_n_empty", empty_o[1], 1);
    chk("fw_n_cnt", cnt_b, 1);
    @(negedge clk);
    chk("fw_n1_vld", vld_o[1], 1);
    chk("fw_n1_empty", empty_o[1], 0);
    e = sbq.pop_front();
    chk("fw_n1_data", data_o[1], e);
    rd = 1;
    @(negedge clk);
    rd = 0;
    chk("fw_pop_vld", vld_o[1], 0);
    chk("fw_pop_cnt", cnt_b, 0);
    rd = 1;
    @(negedge clk);
    rd = 0;
    chk("fw_udf", udf_o[1], 1);
    chk("fw_udf_cnt", cnt_b, 0);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("fw_udf_clr", udf_o[1], 0);
    for (int i = 0; i < 8; i++) begin
      wr = 1; wd = 8'(8'h10 + i);
      sbq.push_back(wd);
      @(negedge clk);
    end
    wr = 0;
    @(negedge clk);
    chk("fw_cnt8", cnt_b, 8);
    for (int i = 0; i < 8; i++) begin
      chk("fw_burst_vld", vld_o[1], 1);
      chk("fw_burst_cnt", cnt_b, 8 - i);
      e = sbq.pop_front();
      chk("fw_burst_data", data_o[1], e);
      rd = 1;
      @(negedge clk);
    end
    rd = 0;
    chk("fw_end_vld", vld_o[1], 0);
    chk("fw_end_empty", empty_o[1], 1);
    chk("fw_end_cnt", cnt_b, 0);

    // depth 5, thresholds 4/1
    do_reset(2, 5, 4, 1);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].w, 8'(8'h40 + i), tbl[i].r, 0);
      chk("tb_cnt",  cnt_c,       tbl[i].cnt);
      chk("tb_ae",   aempty_o[2], tbl[i].ae);
      chk("tb_af",   afull_o[2],  tbl[i].af);
      chk("tb_full", full_o[2],   tbl[i].full);
    end
    step(0, '0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(bit'($urandom_range(0, 1)),
           8'($urandom),
           bit'($urandom_range(0, 1)), 0);
      chk("d5_max", cnt_c <= 4'd5, 1);
    end
    while (mcnt > 0)
      step(0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_fwft.md
# fifo_fwft

Parametrised synchronous FIFO, successor to the fixed-mode FIFO: any depth ≥2 (not limited to powers of two), selectable standard or first-word-fall-through (FWFT) read mode, threshold-based almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between single-clock producer and consumer pipelines wherever a flow-controlled elastic buffer is needed.

## Interface
- FIFO_WIDTH, 8, data word width in bits
- FIFO_DEPTH, 16, capacity in words; ≥2, any integer
- FWFT, 0, 0 = standard (read data one cycle after accepted read); 1 = first-word-fall-through
- AFULL_THRESH, FIFO_DEPTH-2, fifoAlmostFull when count ≥ this; range 1..FIFO_DEPTH
- AEMPTY_THRESH, 2, fifoAlmostEmpty when count ≤ this; range 0..FIFO_DEPTH-1
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- fifoWrEn  input  1  write request
- fifoWrData  input  FIFO_WIDTH  write data, sampled with fifoWrEn
- fifoFull  output  1  count == FIFO_DEPTH
- fifoAlmostFull  output  1  count ≥ AFULL_THRESH
- fifoRdEn  input  1  read request (standard) / pop acknowledge (FWFT)
- fifoRdData  output  FIFO_WIDTH  read data
- fifoRdValid  output  1  fifoRdData holds a valid word this cycle
- fifoEmpty  output  1  no word available to read
- fifoAlmostEmpty  output  1  count ≤ AEMPTY_THRESH
- fifoDataCount  output  $clog2(FIFO_DEPTH)+1  words held
- clrErr  input  1  clears sticky error flags
- fifoOverflow  output  1  sticky: write attempted while full
- fifoUnderflow  output  1  sticky: read attempted while empty

## Operation
- Accepted write: fifoWrEn & !fifoFull; word stored at wrPointer on that edge. Accepted read: fifoRdEn & !fifoEmpty.
- Flags are evaluated from registered state only; a simultaneous read does not enable a write while full, and a simultaneous write does not enable a read while empty.
- Count: +1 on write-only, −1 on read-only, unchanged on both or neither. Includes any word held in the FWFT output register.
- Pointers are $clog2(FIFO_DEPTH) wide and wrap from FIFO_DEPTH−1 to 0.
- Standard mode: fifoEmpty = (count == 0). An accepted read drives mem[rdPointer] onto fifoRdData after the next edge, with fifoRdValid high for exactly one cycle. fifoRdData holds its value otherwise.
- FWFT mode: the output register holds the head word, and fifoEmpty = !fifoRdValid. The RAM read fires when the RAM holds ≥1 word and (the output register is empty or is being popped). Back-to-back pops sustain one word per cycle.
- Errors: fifoWrEn & fifoFull sets fifoOverflow; fifoRdEn & fifoEmpty sets fifoUnderflow. clrErr clears both, but a set in the same cycle wins over the clear.
- Reset (asynchronous, any time, including mid-burst): count 0, pointers 0, fifoEmpty 1, fifoFull 0, fifoAlmostEmpty 1, fifoAlmostFull 0, fifoRdValid 0, fifoRdData 0, both error flags 0. RAM contents are not reset, and stored data is discarded.

## Timing
- Write-to-readable: a write at edge N into an empty FIFO deasserts fifoEmpty after edge N (standard). In FWFT, the word is on fifoRdData with fifoRdValid=1 after edge N+1.
- Standard read latency: 1 edge from accepted read to valid data.
- fifoFull, fifoAlmostFull, fifoAlmostEmpty and fifoDataCount update on the edge of the causing write/read.
- Full throughput: a simultaneous write and read every cycle at any fill level 1..DEPTH−1 leaves count constant.

## Structure
- Package fifo_pkg: constants FIFO_MODE_STD=0, FIFO_MODE_FWFT=1, and a pointer-increment-with-wrap function parametrised by depth.
- Sub-module fifo_ram_2p: simple dual-port array with synchronous write, a registered read with read-enable, and async-reset output register. This register serves as the standard/FWFT output stage.
- The top level holds the pointers, count, flags, error logic and FWFT prefetch control.

## Test plan
- Reset check, DEPTH=16, FWFT=0: write 16 words 0x00..0x0F → fifoFull=1 and count=16 after the 16th edge. A 17th write sets fifoOverflow and leaves count at 16.
- Standard read ordering: read 16 words → data 0x00..0x0F with each fifoRdValid one cycle after its fifoRdEn. The next read sets fifoUnderflow, and clrErr clears it.
- FWFT=1: write 0xA5 at edge N into an empty FIFO → fifoRdData=0xA5, fifoRdValid=1 after edge N+1. Continuous pops of 8 queued words yield one word per cycle, in order.
- DEPTH=5 (non-power-of-two): 20 mixed writes/reads with pointer wrap → data order preserved and count never exceeds 5.
- Thresholds AFULL_THRESH=4, AEMPTY_THRESH=1, DEPTH=5: fill 0→5 → fifoAlmostEmpty drops at count 2 and fifoAlmostFull rises at count 4.
- Assert reset low mid-burst at count=7 → all outputs return to reset values asynchronously. The first write after release reads back correctly.
